// File: rtl/ins_cache_pkg.sv
// Shared geometry defaults, FSM encoding and helpers for the instruction cache.
package ins_cache_pkg;

  localparam int ICACHE_INDEX_W = 5;
  localparam int ICACHE_WORD_W  = 2;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } icache_state_e;

  function automatic int tag_width(input int index_w, input int word_w);
    return 32 - index_w - word_w - 2;
  endfunction

endpackage

// File: rtl/ins_cache_line_ram.sv
// Valid/tag/data line store: combinational word read, single full-line write,
// asynchronous clear of the valid bits only.
module ins_cache_line_ram
  import ins_cache_pkg::*;
#(
  parameter  int INDEX_W = ICACHE_INDEX_W,
  parameter  int WORD_W  = ICACHE_WORD_W,
  localparam int TAG_W   = tag_width(INDEX_W, WORD_W),
  localparam int WORDS   = 1 << WORD_W,
  localparam int LINES   = 1 << INDEX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    rd_index,
  input  logic [WORD_W-1:0]     rd_word,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [WORDS*32-1:0]   wr_line
);

  logic [LINES-1:0]            valid_q;
  logic [TAG_W-1:0]            tag_q  [LINES];
  logic [WORDS-1:0][31:0]      data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; valid gates every read, so their
  // power-up contents never matter and they stay plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache: same-cycle lookup, whole-line
// refill from the memory controller over a word-per-pulse handshake.
module ins_cache
  import ins_cache_pkg::*;
#(
  parameter  int INDEX_W = ICACHE_INDEX_W,
  parameter  int WORD_W  = ICACHE_WORD_W,
  localparam int TAG_W   = tag_width(INDEX_W, WORD_W)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] ins,
  input  logic        clear,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [31:0] mc_data
);

  localparam int              OFF_W = WORD_W + 2;
  localparam int              WORDS = 1 << WORD_W;
  localparam logic [WORD_W-1:0] LAST = '1;

  logic [TAG_W-1:0]       addr_tag;
  logic [INDEX_W-1:0]     addr_index;
  logic [WORD_W-1:0]      addr_word;

  icache_state_e          state;
  logic [WORD_W-1:0]      cnt;
  logic [WORDS-1:0][31:0] fill_buf;
  logic [WORDS-1:0][31:0] wr_line;

  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [31:0]            rd_data;
  logic                   lookup_hit;
  logic                   wr_en;

  assign addr_tag   = addr[31:OFF_W+INDEX_W];
  assign addr_index = addr[OFF_W+INDEX_W-1:OFF_W];
  assign addr_word  = addr[OFF_W-1:2];

  // A flush needs no action: the refill cannot be aborted, and the next IDLE
  // lookup already uses the redirected addr.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clear, addr[1:0]};

  ins_cache_line_ram #(
    .INDEX_W (INDEX_W),
    .WORD_W  (WORD_W)
  ) u_line_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_index (addr_index),
    .rd_word  (addr_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (mc_addr[OFF_W+INDEX_W-1:OFF_W]),
    .wr_tag   (mc_addr[31:OFF_W+INDEX_W]),
    .wr_line  (wr_line)
  );

  assign lookup_hit = rd_valid && (rd_tag == addr_tag);
  assign hit        = rdy && (state == ICACHE_IDLE) && lookup_hit;
  assign ins        = hit ? rd_data : 32'h0;

  assign wr_en = rdy && (state == ICACHE_FILL) && mc_valid && (cnt == LAST);

  // NOTE: assign every always_comb output before any override, so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    wr_line          = fill_buf;
    wr_line[WORDS-1] = mc_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ICACHE_IDLE;
      mc_req   <= 1'b0;
      mc_addr  <= '0;
      cnt      <= '0;
      fill_buf <= '0;
    end else if (rdy) begin
      case (state)
        ICACHE_IDLE: begin
          if (!lookup_hit) begin
            mc_req  <= 1'b1;
            mc_addr <= {addr[31:OFF_W], {OFF_W{1'b0}}};
            cnt     <= '0;
            state   <= ICACHE_FILL;
          end
        end
        ICACHE_FILL: begin
          if (mc_valid) begin
            fill_buf[cnt] <= mc_data;
            cnt           <= cnt + WORD_W'(1);
            if (cnt == LAST) begin
              mc_req <= 1'b0;
              state  <= ICACHE_IDLE;
            end
          end
        end
        default: state <= ICACHE_IDLE;
      endcase
    end
  end

  // The memory controller must only return words while a refill is pending.
  mc_valid_only_in_fill: assert property (
    @(posedge clk) disable iff (!rst) !(rdy && mc_valid && state == ICACHE_IDLE)
  );

endmodule

// File: tb/tb_ins_cache.sv
// Self-checking bench for ins_cache: directed corner sequences, a vector table
// for combinational lookups, and a randomized run against a line-level model.
module tb_ins_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] addr;
  logic        hit;
  logic [31:0] ins;
  logic        clear;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [31:0] mc_data;

  always #5 clk = ~clk;

  ins_cache dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .addr     (addr),
    .hit      (hit),
    .ins      (ins),
    .clear    (clear),
    .mc_req   (mc_req),
    .mc_addr  (mc_addr),
    .mc_valid (mc_valid),
    .mc_data  (mc_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 32 lines of 4 words, refill collected in a queue.
  bit          m_valid [32];
  logic [22:0] m_tag   [32];
  logic [31:0] m_data  [32][4];
  bit          m_filling;
  logic [31:0] m_base;
  logic [31:0] m_words [$];

  function automatic bit m_hit();
    int idx = int'(addr[8:4]);
    return rdy && !m_filling && m_valid[idx] && (m_tag[idx] == addr[31:9]);
  endfunction

  function automatic logic [31:0] m_ins();
    return m_hit() ? m_data[int'(addr[8:4])][int'(addr[3:2])] : 32'h0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_filling = 1'b0;
    m_base    = 32'h0;
    m_words.delete();
  endtask

  // Applies the cache rules for one rising edge, using the pre-edge inputs.
  task automatic m_edge();
    if (!rdy) return;
    if (!m_filling) begin
      if (!m_hit()) begin
        m_filling = 1'b1;
        m_base    = {addr[31:4], 4'h0};
        m_words.delete();
      end
    end else if (mc_valid) begin
      m_words.push_back(mc_data);
      if (m_words.size() == 4) begin
        int idx = int'(m_base[8:4]);
        for (int k = 0; k < 4; k++) m_data[idx][k] = m_words[k];
        m_tag[idx]   = m_base[31:9];
        m_valid[idx] = 1'b1;
        m_filling    = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    check("model.hit",     {31'h0, hit},    {31'h0, m_hit()});
    check("model.ins",     ins,             m_ins());
    check("model.mc_req",  {31'h0, mc_req}, {31'h0, m_filling});
    check("model.mc_addr", mc_addr,         m_base);
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic feed(input logic [31:0] d, input int gap);
    repeat (gap) tick();
    mc_valid = 1'b1;
    mc_data  = d;
    tick();
    mc_valid = 1'b0;
    mc_data  = 32'h0;
  endtask

  typedef struct {
    logic        rdy;
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_ins;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0000, 1'b1, 32'h11};
    vecs[1] = '{1'b1, 32'h0000_0004, 1'b1, 32'h22};
    vecs[2] = '{1'b1, 32'h0000_0008, 1'b1, 32'h33};
    vecs[3] = '{1'b1, 32'h0000_000C, 1'b1, 32'h44};
    vecs[4] = '{1'b1, 32'h0000_000E, 1'b1, 32'h44};
    vecs[5] = '{1'b1, 32'h0000_0001, 1'b1, 32'h11};
    vecs[6] = '{1'b0, 32'h0000_0004, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 32'h0000_0200, 1'b0, 32'h0};

    rst = 1'b0; rdy = 1'b1; addr = 32'h0; clear = 1'b0;
    mc_valid = 1'b0; mc_data = 32'h0;
    m_reset();

    // Reset state
    @(posedge clk); #1;
    check("rst.mc_req",  {31'h0, mc_req}, 32'h0);
    check("rst.mc_addr", mc_addr,         32'h0);
    check("rst.hit",     {31'h0, hit},    32'h0);
    check("rst.ins",     ins,             32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;

    // Cold miss
    check("cold.hit0", {31'h0, hit}, 32'h0);
    tick();
    check("cold.req",  {31'h0, mc_req}, 32'h1);
    check("cold.addr", mc_addr,         32'h0);
    feed(32'h11, 1);
    feed(32'h22, 0);
    feed(32'h33, 2);
    feed(32'h44, 1);
    check("cold.req_drop", {31'h0, mc_req}, 32'h0);

    // Combinational lookups on the filled line, incl. ignored low bits
    for (int i = 0; i < 9; i++) begin
      rdy  = vecs[i].rdy;
      addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d.hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
      check($sformatf("vec%0d.ins", i), ins,          vecs[i].exp_ins);
    end
    rdy  = 1'b1;
    addr = 32'hC;
    tick();
    check("cold.no_req", {31'h0, mc_req}, 32'h0);

    // Conflict eviction
    addr = 32'h200;
    #1;
    check("evict.miss", {31'h0, hit}, 32'h0);
    tick();
    check("evict.req",  {31'h0, mc_req}, 32'h1);
    check("evict.addr", mc_addr,         32'h200);
    feed(32'hA0, 0);
    feed(32'hA1, 1);
    feed(32'hA2, 0);
    feed(32'hA3, 0);
    addr = 32'h204;
    #1;
    check("evict.hit", {31'h0, hit}, 32'h1);
    check("evict.ins", ins,          32'hA1);
    addr = 32'h0;
    #1;
    check("evict.old_miss", {31'h0, hit}, 32'h0);
    tick();
    check("evict.req0",  {31'h0, mc_req}, 32'h1);
    check("evict.addr0", mc_addr,         32'h0);
    feed(32'h11, 0);
    feed(32'h22, 0);
    feed(32'h33, 0);
    feed(32'h44, 0);

    // rdy stall mid-refill
    addr = 32'h100;
    tick();
    check("stall.addr", mc_addr, 32'h100);
    feed(32'h1000, 0);
    feed(32'h1001, 0);
    for (int i = 0; i < 5; i++) begin
      rdy      = 1'b0;
      mc_valid = (i % 2 == 0);
      mc_data  = $urandom;
      tick();
      check("stall.req", {31'h0, mc_req}, 32'h1);
      check("stall.hit", {31'h0, hit},    32'h0);
    end
    rdy = 1'b1; mc_valid = 1'b0; mc_data = 32'h0;
    feed(32'h1002, 1);
    feed(32'h1003, 0);
    for (int k = 0; k < 4; k++) begin
      addr = 32'h100 + 32'(4 * k);
      #1;
      check("stall.ins", ins, 32'h1000 + 32'(k));
    end

    // Flush during refill
    addr = 32'h40;
    tick();
    check("flush.addr", mc_addr, 32'h40);
    feed(32'h4000, 0);
    clear = 1'b1;
    addr  = 32'h80;
    tick();
    clear = 1'b0;
    check("flush.req_held",  {31'h0, mc_req}, 32'h1);
    check("flush.addr_held", mc_addr,         32'h40);
    feed(32'h4001, 0);
    feed(32'h4002, 1);
    feed(32'h4003, 0);
    check("flush.req_drop", {31'h0, mc_req}, 32'h0);
    tick();
    check("flush.req_new",  {31'h0, mc_req}, 32'h1);
    check("flush.addr_new", mc_addr,         32'h80);
    for (int k = 0; k < 4; k++) feed(32'h8000 + 32'(k), k % 2);
    addr = 32'h44;
    #1;
    check("flush.hit", {31'h0, hit}, 32'h1);
    check("flush.ins", ins,          32'h4001);

    // Asynchronous reset mid-refill
    addr = 32'h300;
    tick();
    check("areset.addr", mc_addr, 32'h300);
    feed(32'h3000, 0);
    feed(32'h3001, 0);
    feed(32'h3002, 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1;
    check("areset.req", {31'h0, mc_req}, 32'h0);
    check("areset.hit", {31'h0, hit},    32'h0);
    @(posedge clk); #1;
    rst  = 1'b1;
    addr = 32'h0;
    #1;
    check("areset.cold", {31'h0, hit}, 32'h0);
    tick();
    check("areset.req0", {31'h0, mc_req}, 32'h1);
    check("areset.addr0", mc_addr,        32'h0);
    for (int k = 0; k < 4; k++) feed(32'h55 + 32'(k), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        addr = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4)
             | 32'($urandom_range(0, 15));
      mc_valid = m_filling && ($urandom_range(0, 1) == 1);
      mc_data  = $urandom;
      tick();
    end
    mc_valid = 1'b0;
    clear    = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
